// File: rtl/network_interface_pkg.sv
// ============================================================================
// Module      : pa_noc (package)
// Description : Shared widths and packet layout for the mesh network interface.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pa_noc;

    localparam int PAYLOAD_WIDTH = 8;
    localparam int COORD_WIDTH   = 2;
    localparam int PACKET_WIDTH  = PAYLOAD_WIDTH + 2*COORD_WIDTH;

    // Field order puts dstCol in the least-significant bits.
    typedef struct packed {
        logic [PAYLOAD_WIDTH-1:0] payload;
        logic [COORD_WIDTH-1:0]   dstRow;
        logic [COORD_WIDTH-1:0]   dstCol;
    } packet_t;

    function automatic packet_t fn_packPacket(
        input logic [PAYLOAD_WIDTH-1:0] payload,
        input logic [COORD_WIDTH-1:0]   dstRow,
        input logic [COORD_WIDTH-1:0]   dstCol
    );
        packet_t pkt;
        pkt.payload = payload;
        pkt.dstRow  = dstRow;
        pkt.dstCol  = dstCol;
        return pkt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/network_interface_if.sv
// ============================================================================
// Module      : network_interface_if
// Description : Core-side, router-side and status signals of the network interface.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface network_interface_if;
    import pa_noc::*;

    logic [PAYLOAD_WIDTH-1:0] i_txPayload;
    logic [COORD_WIDTH-1:0]   i_txDstRow;
    logic [COORD_WIDTH-1:0]   i_txDstCol;
    logic                     i_txValid;
    logic                     o_txReady;
    logic [PACKET_WIDTH-1:0]  o_router;
    logic                     o_routerValid;
    logic                     i_routerReady;
    logic [PACKET_WIDTH-1:0]  i_router;
    logic                     i_routerValid;
    logic                     o_routerReady;
    logic [PAYLOAD_WIDTH-1:0] o_rxPayload;
    logic                     o_rxValid;
    logic                     i_rxReady;
    logic                     o_misrouteErr;
    logic [15:0]              o_txCount;
    logic [15:0]              o_rxCount;

    modport slave (
        input  i_txPayload, i_txDstRow, i_txDstCol, i_txValid, i_routerReady,
               i_router, i_routerValid, i_rxReady,
        output o_txReady, o_router, o_routerValid, o_routerReady, o_rxPayload,
               o_rxValid, o_misrouteErr, o_txCount, o_rxCount
    );

    modport master (
        output i_txPayload, i_txDstRow, i_txDstCol, i_txValid, i_routerReady,
               i_router, i_routerValid, i_rxReady,
        input  o_txReady, o_router, o_routerValid, o_routerReady, o_rxPayload,
               o_rxValid, o_misrouteErr, o_txCount, o_rxCount
    );

endinterface

`default_nettype wire

// File: rtl/network_interface_fifo.sv
// ============================================================================
// Module      : noc_fifo
// Description : Power-of-two depth FIFO with valid/ready on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module noc_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  wire logic             i_clk,
    input  wire logic             i_arst_n,
    input  wire logic [WIDTH-1:0] i_data,
    input  wire logic             i_valid,
    output logic                  o_ready,
    output logic [WIDTH-1:0]      o_data,
    output logic                  o_valid,
    input  wire logic             i_ready
);

    localparam int                c_ptrWidth = $clog2(DEPTH);
    localparam logic [c_ptrWidth:0] c_full   = (c_ptrWidth+1)'(DEPTH);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [c_ptrWidth-1:0] wrPtr_q, wrPtr_d;
    logic [c_ptrWidth-1:0] rdPtr_q, rdPtr_d;
    logic [c_ptrWidth:0]   count_q, count_d;
    logic                  w_push;
    logic                  w_pop;

    assign o_ready = (count_q != c_full);
    assign o_valid = (count_q != '0);
    // Head is masked while empty so stale entries never reach the output.
    assign o_data  = o_valid ? mem_q[rdPtr_q] : '0;
    assign w_push  = i_valid && o_ready;
    assign w_pop   = o_valid && i_ready;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (w_push) wrPtr_d = wrPtr_q + c_ptrWidth'(1);
        if (w_pop)  rdPtr_d = rdPtr_q + c_ptrWidth'(1);
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + (c_ptrWidth+1)'(1);
            2'b01:   count_d = count_q - (c_ptrWidth+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) mem_q[wrPtr_q] <= i_data;
    end

endmodule

`default_nettype wire

// File: rtl/network_interface.sv
// ============================================================================
// Module      : network_interface
// Description : Mesh NoC endpoint: buffered tx path to the router, single-stage rx path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module network_interface
    import pa_noc::*;
#(
    parameter int                     GRID_WIDTH = 4,
    parameter logic [COORD_WIDTH-1:0] ROUTER_ROW = '0,
    parameter logic [COORD_WIDTH-1:0] ROUTER_COL = '0,
    parameter int                     TX_DEPTH   = 4
) (
    input  wire logic          i_clk,
    input  wire logic          i_arst_n,
    network_interface_if.slave bus
);

    if (TX_DEPTH < 2 || (TX_DEPTH & (TX_DEPTH - 1)) != 0) begin : g_badDepth
        $error("network_interface: TX_DEPTH must be a power of two >= 2");
    end

    if (GRID_WIDTH < 1 || GRID_WIDTH > (1 << COORD_WIDTH) ||
        int'(ROUTER_ROW) >= GRID_WIDTH || int'(ROUTER_COL) >= GRID_WIDTH) begin : g_badGrid
        $error("network_interface: router coordinates outside the mesh");
    end

    packet_t                  w_txPacket;
    packet_t                  w_rxPacket;
    logic                     w_fifoValid;
    logic                     w_routerReady;
    logic                     w_txHandshake;
    logic                     w_rxLoad;
    logic                     w_rxDrain;

    logic                     rxValid_q,   rxValid_d;
    logic [PAYLOAD_WIDTH-1:0] rxPayload_q, rxPayload_d;
    logic                     misroute_q,  misroute_d;
    logic [15:0]              txCount_q,   txCount_d;
    logic [15:0]              rxCount_q,   rxCount_d;

    assign w_txPacket = fn_packPacket(bus.i_txPayload, bus.i_txDstRow, bus.i_txDstCol);

    noc_fifo #(
        .WIDTH (PACKET_WIDTH),
        .DEPTH (TX_DEPTH)
    ) u_txFifo (
        .i_clk    (i_clk),
        .i_arst_n (i_arst_n),
        .i_data   (w_txPacket),
        .i_valid  (bus.i_txValid),
        .o_ready  (bus.o_txReady),
        .o_data   (bus.o_router),
        .o_valid  (w_fifoValid),
        .i_ready  (bus.i_routerReady)
    );

    assign bus.o_routerValid = w_fifoValid;
    assign w_txHandshake     = w_fifoValid && bus.i_routerReady;

    // The rx register may reload in the same cycle the core drains it.
    assign w_routerReady     = !rxValid_q || bus.i_rxReady;
    assign bus.o_routerReady = w_routerReady;
    assign w_rxPacket        = packet_t'(bus.i_router);
    assign w_rxLoad          = bus.i_routerValid && w_routerReady;
    assign w_rxDrain         = rxValid_q && bus.i_rxReady;

    always_comb begin
        rxValid_d   = rxValid_q;
        rxPayload_d = rxPayload_q;
        misroute_d  = misroute_q;
        rxCount_d   = rxCount_q;
        txCount_d   = txCount_q;
        if (w_txHandshake) txCount_d = txCount_q + 16'd1;
        if (w_rxDrain) begin
            rxValid_d = 1'b0;
            rxCount_d = rxCount_q + 16'd1;
        end
        if (w_rxLoad) begin
            rxValid_d   = 1'b1;
            rxPayload_d = w_rxPacket.payload;
            if (w_rxPacket.dstRow != ROUTER_ROW || w_rxPacket.dstCol != ROUTER_COL)
                misroute_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            rxValid_q   <= 1'b0;
            rxPayload_q <= '0;
            misroute_q  <= 1'b0;
            txCount_q   <= '0;
            rxCount_q   <= '0;
        end else begin
            rxValid_q   <= rxValid_d;
            rxPayload_q <= rxPayload_d;
            misroute_q  <= misroute_d;
            txCount_q   <= txCount_d;
            rxCount_q   <= rxCount_d;
        end
    end

    assign bus.o_rxValid     = rxValid_q;
    assign bus.o_rxPayload   = rxPayload_q;
    assign bus.o_misrouteErr = misroute_q;
    assign bus.o_txCount     = txCount_q;
    assign bus.o_rxCount     = rxCount_q;

endmodule

`default_nettype wire

// File: tb/tb_network_interface.sv
// ============================================================================
// Module      : tb_network_interface
// Description : Directed self-checking bench for network_interface (router at 1,2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_network_interface;

    logic clk;
    logic arst_n;
    int   errors;
    int   checks;

    network_interface_if bus ();

    network_interface #(
        .GRID_WIDTH (4),
        .ROUTER_ROW (2'd1),
        .ROUTER_COL (2'd2),
        .TX_DEPTH   (4)
    ) dut (
        .i_clk    (clk),
        .i_arst_n (arst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_tx(input logic [7:0] pl, input logic [1:0] row, input logic [1:0] col);
        bus.i_txPayload = pl;
        bus.i_txDstRow  = row;
        bus.i_txDstCol  = col;
        bus.i_txValid   = 1'b1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        arst_n = 1'b0;
        bus.i_txPayload   = '0;
        bus.i_txDstRow    = '0;
        bus.i_txDstCol    = '0;
        bus.i_txValid     = 1'b0;
        bus.i_routerReady = 1'b0;
        bus.i_router      = '0;
        bus.i_routerValid = 1'b0;
        bus.i_rxReady     = 1'b0;
        #2;
        chk("rst_routerValid", bus.o_routerValid, 0);
        chk("rst_rxValid",     bus.o_rxValid, 0);
        chk("rst_misroute",    bus.o_misrouteErr, 0);
        chk("rst_txCount",     bus.o_txCount, 0);
        chk("rst_rxCount",     bus.o_rxCount, 0);
        chk("rst_router",      bus.o_router, 0);
        chk("rst_rxPayload",   bus.o_rxPayload, 0);
        chk("rst_txReady",     bus.o_txReady, 1);
        chk("rst_routerReady", bus.o_routerReady, 1);
        @(negedge clk);
        arst_n = 1'b1;
        tick();
        chk("post_rst_routerValid", bus.o_routerValid, 0);

        // Single packet, router always ready
        bus.i_routerReady = 1'b1;
        send_tx(8'hA5, 2'd3, 2'd0);
        tick();
        bus.i_txValid = 1'b0;
        chk("s1_routerValid", bus.o_routerValid, 1);
        chk("s1_router",      bus.o_router, 32'hA5C);
        chk("s1_txCount0",    bus.o_txCount, 0);
        tick();
        chk("s1_txCount1",    bus.o_txCount, 1);
        chk("s1_empty",       bus.o_routerValid, 0);

        // Fill FIFO with router stalled, then drain in order
        bus.i_routerReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_tx(8'h10 + 8'(i), 2'd0, 2'd1);
            #1;
            chk("s2_txReady_fill", bus.o_txReady, 1);
            tick();
        end
        chk("s2_full", bus.o_txReady, 0);
        send_tx(8'h14, 2'd0, 2'd1);
        tick();
        chk("s2_still_full", bus.o_txReady, 0);
        chk("s2_head0",      bus.o_router, 32'h101);
        bus.i_routerReady = 1'b1;
        tick();
        chk("s2_head1",      bus.o_router, 32'h111);
        chk("s2_ready_again", bus.o_txReady, 1);
        tick();
        bus.i_txValid = 1'b0;
        chk("s2_head2", bus.o_router, 32'h121);
        tick();
        chk("s2_head3", bus.o_router, 32'h131);
        tick();
        chk("s2_head4", bus.o_router, 32'h141);
        tick();
        chk("s2_empty",   bus.o_routerValid, 0);
        chk("s2_txCount", bus.o_txCount, 6);

        // Rx to own address with core stalling one cycle
        bus.i_routerReady = 1'b0;
        bus.i_router      = 12'h3C6;
        bus.i_routerValid = 1'b1;
        bus.i_rxReady     = 1'b0;
        #1;
        chk("s3_routerReady", bus.o_routerReady, 1);
        tick();
        bus.i_routerValid = 1'b0;
        chk("s3_rxValid_a",   bus.o_rxValid, 1);
        chk("s3_rxPayload_a", bus.o_rxPayload, 32'h3C);
        chk("s3_backpressure", bus.o_routerReady, 0);
        tick();
        chk("s3_rxValid_b",   bus.o_rxValid, 1);
        chk("s3_rxPayload_b", bus.o_rxPayload, 32'h3C);
        chk("s3_rxCount0",    bus.o_rxCount, 0);
        bus.i_rxReady = 1'b1;
        tick();
        chk("s3_rxValid_c", bus.o_rxValid, 0);
        chk("s3_rxCount1",  bus.o_rxCount, 1);
        chk("s3_misroute",  bus.o_misrouteErr, 0);

        // Misrouted packet followed by back-to-back good packets
        bus.i_router      = 12'h770;
        bus.i_routerValid = 1'b1;
        tick();
        chk("s4_payload77", bus.o_rxPayload, 32'h77);
        chk("s4_misroute1", bus.o_misrouteErr, 1);
        chk("s4_rxCount1",  bus.o_rxCount, 1);
        bus.i_router = 12'h556;
        tick();
        chk("s4_payload55", bus.o_rxPayload, 32'h55);
        chk("s4_misroute2", bus.o_misrouteErr, 1);
        chk("s4_rxCount2",  bus.o_rxCount, 2);
        bus.i_router = 12'h666;
        tick();
        chk("s4_payload66", bus.o_rxPayload, 32'h66);
        chk("s4_rxCount3",  bus.o_rxCount, 3);
        bus.i_routerValid = 1'b0;
        tick();
        chk("s4_rxValid0",  bus.o_rxValid, 0);
        chk("s4_rxCount4",  bus.o_rxCount, 4);
        chk("s4_misroute3", bus.o_misrouteErr, 1);

        // Reset with three queued tx packets and a held rx packet
        bus.i_rxReady     = 1'b0;
        bus.i_router      = 12'h3C6;
        bus.i_routerValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_tx(8'h80 + 8'(i), 2'd0, 2'd1);
            tick();
        end
        bus.i_txValid     = 1'b0;
        bus.i_routerValid = 1'b0;
        chk("s5_routerValid_pre", bus.o_routerValid, 1);
        chk("s5_rxValid_pre",     bus.o_rxValid, 1);
        chk("s5_txReady_pre",     bus.o_txReady, 1);
        arst_n = 1'b0;
        #1;
        chk("s5_routerValid_rst", bus.o_routerValid, 0);
        chk("s5_router_rst",      bus.o_router, 0);
        chk("s5_rxValid_rst",     bus.o_rxValid, 0);
        chk("s5_misroute_rst",    bus.o_misrouteErr, 0);
        chk("s5_rxCount_rst",     bus.o_rxCount, 0);
        chk("s5_txCount_rst",     bus.o_txCount, 0);
        #1;
        arst_n = 1'b1;
        tick();
        chk("s5_no_stale_valid", bus.o_routerValid, 0);
        chk("s5_no_stale_rx",    bus.o_rxValid, 0);
        send_tx(8'h9A, 2'd0, 2'd1);
        tick();
        bus.i_txValid = 1'b0;
        chk("s5_new_head", bus.o_router, 32'h9A1);
        bus.i_routerReady = 1'b1;
        tick();
        chk("s5_single_entry", bus.o_routerValid, 0);
        chk("s5_txCount1",     bus.o_txCount, 1);

        // Long stream to exercise counter wrap
        arst_n = 1'b0;
        #1;
        arst_n = 1'b1;
        send_tx(8'h01, 2'd3, 2'd3);
        repeat (70000) tick();
        chk("s6_txReady_stream", bus.o_txReady, 1);
        bus.i_txValid = 1'b0;
        tick();
        chk("s6_txCount_wrap", bus.o_txCount, 4464);
        chk("s6_empty",        bus.o_routerValid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
